// File: rtl/dll_pkg.sv
// Shared definitions for the early/late symbol-timing loop: phase slots,
// controller states and the saturating magnitude used by the detector.
package dll_pkg;

    localparam logic [1:0] PH_EARLY = 2'd0;
    localparam logic [1:0] PH_LATE  = 2'd2;
    localparam logic [1:0] PH_STB   = 2'd3;

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_DECIDE  = 2'd1,
        ST_HOLDOFF = 2'd2
    } dll_state_e;

    // |x| limited to 15 bits of magnitude so -32768 cannot wrap back negative.
    function automatic logic [15:0] sat_abs(input logic signed [15:0] x);
        logic [15:0] r;
        if (x == 16'sh8000) begin
            r = 16'h7fff;
        end else if (x < 16'sd0) begin
            r = $unsigned(-x);
        end else begin
            r = $unsigned(x);
        end
        return r;
    endfunction

endpackage

// File: rtl/el_timing_loop_if.sv
// Sampler/demod side of the symbol DLL: samples in, phase/strobe/status out.
// Samples are qualified by ph_out==3 (sym_stb); there is no back-pressure.
interface el_timing_loop_if
    import dll_pkg::*;
#(
    parameter int ACC_W = 21
);
    logic signed [15:0]      s_e;
    logic signed [15:0]      s_d;
    logic [1:0]              ph_out;
    logic                    sym_stb;
    logic                    adj_adv;
    logic                    adj_ret;
    logic                    lock;
    logic signed [ACC_W-1:0] ted_out;
    dll_state_e              state_dbg;

    modport master (
        output s_e, s_d,
        input  ph_out, sym_stb, adj_adv, adj_ret, lock, ted_out, state_dbg
    );

    modport slave (
        input  s_e, s_d,
        output ph_out, sym_stb, adj_adv, adj_ret, lock, ted_out, state_dbg
    );

endinterface

// File: rtl/el_ted_abs.sv
// Non-coherent early-late detector datapath: |early| - |late| with saturating
// magnitudes, giving a 17-bit signed error per symbol.
module el_ted_abs
    import dll_pkg::*;
(
    input  logic signed [15:0] s_e_i,
    input  logic signed [15:0] s_d_i,
    output logic signed [16:0] diff_o
);

    logic [15:0] mag_e;
    logic [15:0] mag_d;

    always_comb begin
        mag_e  = sat_abs(s_e_i);
        mag_d  = sat_abs(s_d_i);
        diff_o = $signed({1'b0, mag_e}) - $signed({1'b0, mag_d});
    end

endmodule

// File: rtl/el_timing_loop.sv
// Symbol DLL controller: accumulates early-late error over ACC_LEN symbols,
// then advances, retards or holds the 4x sampling phase and tracks lock.
module el_timing_loop
    import dll_pkg::*;
#(
    parameter int          ACC_LEN     = 16,
    parameter int unsigned THRESH      = 4096,
    parameter int          HOLDOFF_SYM = 8,
    parameter int          LOCK_WIN    = 4
) (
    input  logic             clk4,
    input  logic             reset,
    el_timing_loop_if.slave  bus
);

    localparam int ACC_W  = 17 + $clog2(ACC_LEN);
    localparam int SYM_W  = $clog2(ACC_LEN);
    localparam int HOLD_W = (HOLDOFF_SYM > 1) ? $clog2(HOLDOFF_SYM) : 1;
    localparam int LC_W   = $clog2(LOCK_WIN + 1);

    localparam logic [SYM_W-1:0]  SYM_LAST  = SYM_W'(ACC_LEN - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_SYM - 1);
    localparam logic [LC_W-1:0]   LOCK_MAX  = LC_W'(LOCK_WIN);
    localparam logic signed [33:0] THR_P    = 34'(THRESH);
    localparam logic signed [33:0] THR_N    = -THR_P;

    dll_state_e              state_q, state_d;
    logic [1:0]              ph_q, ph_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] ted_q, ted_d;
    logic [SYM_W-1:0]        sym_cnt_q, sym_cnt_d;
    logic [HOLD_W-1:0]       hold_cnt_q, hold_cnt_d;
    logic [LC_W-1:0]         lock_cnt_q, lock_cnt_d;
    logic                    lock_q, lock_d;
    logic                    adv_q, adv_d;
    logic                    ret_q, ret_d;

    logic signed [16:0]      diff;
    logic signed [33:0]      acc_wide;
    logic                    stb;

    el_ted_abs u_ted (
        .s_e_i  (bus.s_e),
        .s_d_i  (bus.s_d),
        .diff_o (diff)
    );

    assign stb      = (ph_q == PH_STB);
    assign acc_wide = 34'(acc_q);

    always_ff @(posedge clk4) begin
        if (!reset) begin
            state_q    <= ST_ACCUM;
            ph_q       <= PH_EARLY;
            acc_q      <= '0;
            ted_q      <= '0;
            sym_cnt_q  <= '0;
            hold_cnt_q <= '0;
            lock_cnt_q <= '0;
            lock_q     <= 1'b0;
            adv_q      <= 1'b0;
            ret_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            acc_q      <= acc_d;
            ted_q      <= ted_d;
            sym_cnt_q  <= sym_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            lock_cnt_q <= lock_cnt_d;
            lock_q     <= lock_d;
            adv_q      <= adv_d;
            ret_q      <= ret_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q + 2'd1;
        acc_d      = acc_q;
        ted_d      = ted_q;
        sym_cnt_d  = sym_cnt_q;
        hold_cnt_d = hold_cnt_q;
        lock_cnt_d = lock_cnt_q;
        lock_d     = lock_q;
        adv_d      = 1'b0;
        ret_d      = 1'b0;

        unique case (state_q)
            ST_ACCUM: begin
                if (stb) begin
                    acc_d = acc_q + ACC_W'(diff);
                    if (sym_cnt_q == SYM_LAST) begin
                        sym_cnt_d = '0;
                        state_d   = ST_DECIDE;
                    end else begin
                        sym_cnt_d = sym_cnt_q + SYM_W'(1);
                    end
                end
            end

            // Entered with ph==0; advance skips a phase, retard repeats one.
            ST_DECIDE: begin
                ted_d = acc_q;
                acc_d = '0;
                if (acc_wide > THR_P) begin
                    adv_d = 1'b1;
                    ph_d  = ph_q + 2'd2;
                end else if (acc_wide < THR_N) begin
                    ret_d = 1'b1;
                    ph_d  = ph_q;
                end
                if (adv_d || ret_d) begin
                    lock_cnt_d = '0;
                    lock_d     = 1'b0;
                    state_d    = ST_HOLDOFF;
                end else begin
                    if (lock_cnt_q != LOCK_MAX) begin
                        lock_cnt_d = lock_cnt_q + LC_W'(1);
                    end
                    if (lock_cnt_d == LOCK_MAX) begin
                        lock_d = 1'b1;
                    end
                    state_d = ST_ACCUM;
                end
            end

            ST_HOLDOFF: begin
                if (stb) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        hold_cnt_d = '0;
                        sym_cnt_d  = '0;
                        state_d    = ST_ACCUM;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    assign bus.ph_out    = ph_q;
    assign bus.sym_stb   = stb;
    assign bus.adj_adv   = adv_q;
    assign bus.adj_ret   = ret_q;
    assign bus.lock      = lock_q;
    assign bus.ted_out   = ted_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_el_timing_loop.sv
// Bench for el_timing_loop: window-level reference of the early-late loop
// (sum of magnitude differences, threshold decision, holdoff, lock count).
module tb_el_timing_loop;
    import dll_pkg::*;

    localparam int    ACC_LEN     = 16;
    localparam int    THRESH      = 4096;
    localparam int    HOLDOFF_SYM = 8;
    localparam int    LOCK_WIN    = 4;
    localparam int    ACC_W       = 21;

    logic clk4;
    logic reset;

    el_timing_loop_if #(.ACC_W(ACC_W)) bus ();

    el_timing_loop #(
        .ACC_LEN     (ACC_LEN),
        .THRESH      (THRESH),
        .HOLDOFF_SYM (HOLDOFF_SYM),
        .LOCK_WIN    (LOCK_WIN)
    ) dut (
        .clk4  (clk4),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset
    initial clk4 = 1'b0;
    always #5 clk4 = ~clk4;

    int total = 0;
    int bad   = 0;
    int lock_cnt = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk4);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic int mag(input int x);
        if (x == -32768) return 32767;
        return (x < 0) ? -x : x;
    endfunction

    // Steps until the sampler strobe is visible; at most one symbol period.
    task automatic wait_stb(output int n);
        n = 0;
        while (bus.sym_stb !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        if (bus.sym_stb !== 1'b1) check("stb_timeout", bus.sym_stb, 1);
    endtask

    task automatic pick(input int mode, input int ce, input int cd,
                        output logic signed [15:0] e, output logic signed [15:0] d);
        case (mode)
            0: begin
                e = 16'(ce);
                d = 16'(cd);
            end
            1: begin
                e = 16'($urandom_range(0, 65535));
                d = 16'($urandom_range(0, 65535));
            end
            default: begin
                e = 16'(int'($urandom_range(0, 1400)) - 700);
                d = 16'(int'($urandom_range(0, 1400)) - 700);
            end
        endcase
    endtask

    // One decision window, plus the ignored holdoff symbols if it adjusted.
    task automatic run_window(input int mode, input int ce, input int cd);
        longint acc;
        int n;
        logic signed [15:0] e, d;
        bit adv, ret;
        acc = 0;
        for (int k = 0; k < ACC_LEN; k++) begin
            wait_stb(n);
            if (k > 0) check("stb_spacing", n, 3);
            pick(mode, ce, cd, e, d);
            bus.s_e = e;
            bus.s_d = d;
            acc += longint'(mag(int'(e)) - mag(int'(d)));
            step();
        end
        check("decide_ph", bus.ph_out, 0);
        check("decide_state", bus.state_dbg, ST_DECIDE);
        step();
        adv = (acc > THRESH);
        ret = (acc < -THRESH);
        if (adv || ret) lock_cnt = 0;
        else if (lock_cnt < LOCK_WIN) lock_cnt++;
        check("ted_out", bus.ted_out, acc);
        check("adj_adv", bus.adj_adv, adv);
        check("adj_ret", bus.adj_ret, ret);
        check("ph_after_decide", bus.ph_out, adv ? 2 : (ret ? 0 : 1));
        check("lock", bus.lock, (lock_cnt == LOCK_WIN));
        step();
        check("adv_one_cycle", bus.adj_adv, 0);
        check("ret_one_cycle", bus.adj_ret, 0);
        if (ret) check("ret_ph_hold", bus.ph_out, 1);
        if (adv || ret) begin
            for (int h = 0; h < HOLDOFF_SYM; h++) begin
                wait_stb(n);
                check("holdoff_state", bus.state_dbg, ST_HOLDOFF);
                bus.s_e = 16'($urandom_range(0, 65535));
                bus.s_d = 16'($urandom_range(0, 65535));
                step();
            end
            check("holdoff_exit", bus.state_dbg, ST_ACCUM);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ph"}, bus.ph_out, 0);
        check({tag, "_stb"}, bus.sym_stb, 0);
        check({tag, "_adv"}, bus.adj_adv, 0);
        check({tag, "_ret"}, bus.adj_ret, 0);
        check({tag, "_lock"}, bus.lock, 0);
        check({tag, "_ted"}, bus.ted_out, 0);
        check({tag, "_state"}, bus.state_dbg, ST_ACCUM);
    endtask

    initial begin
        int n;
        reset   = 1'b0;
        bus.s_e = '0;
        bus.s_d = '0;
        repeat (3) step();
        check_reset_state("rst");
        reset = 1'b1;

        // Zero input: no adjustments, lock on the 4th decision.
        for (int w = 0; w < 4; w++) run_window(0, 0, 0);
        // Small positive error stays inside the threshold.
        run_window(0, 300, 100);

        // Reset after 7 accumulated symbols drops the partial window and lock.
        for (int k = 0; k < 7; k++) begin
            wait_stb(n);
            bus.s_e = 16'sd5000;
            bus.s_d = 16'sd0;
            step();
        end
        check("lock_pre_reset", bus.lock, (lock_cnt == LOCK_WIN));
        reset = 1'b0;
        step();
        check_reset_state("mid_rst");
        reset = 1'b1;
        lock_cnt = 0;
        run_window(0, 300, 100);

        // Regain lock, then a large early error must drop it.
        for (int w = 0; w < 3; w++) run_window(0, 0, 0);
        run_window(0, 1000, 200);
        run_window(0, -200, -1000);
        run_window(0, -32768, 0);

        for (int w = 0; w < 12; w++) run_window((w % 3 == 0) ? 1 : 2, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
